// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: next-PC opcodes,
// fetch FSM state encoding and default reset PC.
package cpu_defs;

    localparam logic [3:0] NPC_PLUS4  = 4'd0;
    localparam logic [3:0] NPC_BRANCH = 4'd1;
    localparam logic [3:0] NPC_JUMP   = 4'd2;
    localparam logic [3:0] NPC_JR     = 4'd3;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC selection for the fetch stage.
// Flags a misaligned JR target and then keeps the PC.
module npc_calc
    import cpu_defs::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [3:0]  npc_op,
    input  logic [31:0] ra,
    output logic [31:0] pc_plus4,
    output logic [31:0] npc,
    output logic        misalign
);

    assign pc_plus4 = pc + 32'd4;

    // Select the committed next PC; unknown opcodes fall back to PLUS4
    always_comb begin
        npc      = pc_plus4;
        misalign = 1'b0;
        case (npc_op)
            NPC_BRANCH: npc = pc_plus4
                            + {{14{instr[15]}}, instr[15:0], 2'b00};
            NPC_JUMP:   npc = {pc_plus4[31:28], instr[25:0], 2'b00};
            NPC_JR: begin
                if (ra[1:0] != 2'b00) begin
                    npc      = pc;
                    misalign = 1'b1;
                end else begin
                    npc = ra;
                end
            end
            default:    npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-outstanding imem
// request FSM, decode handoff and next-PC commit.
module fetch_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [3:0]  npc_op,
    input  logic [31:0] ra,
    output logic        exc_misalign
);

    fetch_state_e state;
    fetch_state_e state_nxt;
    logic [31:0]  npc;
    logic         misalign;
    logic         commit;

    npc_calc u_npc (
        .pc       (pc),
        .instr    (instr),
        .npc_op   (npc_op),
        .ra       (ra),
        .pc_plus4 (pc_plus4),
        .npc      (npc),
        .misalign (misalign)
    );

    assign commit = (state == ST_HOLD) && instr_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_REQ;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_REQ:  if (imem_req_ready) state_nxt = ST_WAIT;
            ST_WAIT: if (imem_rsp_valid) state_nxt = ST_HOLD;
            ST_HOLD: if (instr_ready)
                         state_nxt = misalign ? ST_HALT : ST_REQ;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_REQ;
        endcase
    end

    // Outputs; request is masked while reset is asserted
    always_comb begin
        imem_req_valid = (state == ST_REQ) && rstn;
        instr_valid    = (state == ST_HOLD) && rstn;
        imem_addr      = {pc[31:2], 2'b00};
    end

    // PC, instruction and sticky exception registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc           <= RESET_PC;
            instr        <= 32'd0;
            exc_misalign <= 1'b0;
        end else begin
            if ((state == ST_WAIT) && imem_rsp_valid)
                instr <= imem_rsp_data;
            if (commit) begin
                if (misalign) exc_misalign <= 1'b1;
                else          pc           <= npc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Drives a scripted imem and decode side, checks handshakes/PC.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [3:0]  npc_op;
    logic [31:0] ra;
    logic        exc_misalign;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int req_cnt = 0;
    int exp_req = 0;
    int hold_cyc = 0;
    int prev_hold = 0;

    fetch_unit dut (
        .clk            (clk),
        .rstn           (rstn),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .npc_op         (npc_op),
        .ra             (ra),
        .exc_misalign   (exc_misalign)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_req_valid && imem_req_ready) req_cnt <= req_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        instr_ready = 1'b0;
        tick();
        tick();
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_exc", {31'd0, exc_misalign}, 32'd0);
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_instr", instr, 32'd0);
        rstn = 1'b1;
    endtask

    // One fetch: optional request stall, response latency >= 1
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                         input int stall, input int lat);
        int n = 0;
        while (!imem_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", {31'd0, imem_req_valid}, 32'd1);
        chk("req_addr", imem_addr, addr);
        imem_req_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("stall_addr", imem_addr, addr);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        exp_req++;
        chk("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
        for (int i = 1; i < lat; i++) begin
            tick();
            chk("wait_req", {31'd0, imem_req_valid}, 32'd0);
            chk("wait_ivalid", {31'd0, instr_valid}, 32'd0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hX;
        hold_cyc = cyc;
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold_instr", instr, data);
        chk("hold_pc", pc, addr);
    endtask

    // Commit the held instruction after `hold` cycles of back-pressure
    task automatic commit(input logic [3:0] op, input logic [31:0] r,
                          input int hold);
        logic [31:0] i0 = instr;
        logic [31:0] p0 = pc;
        instr_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bp_valid", {31'd0, instr_valid}, 32'd1);
            chk("bp_instr", instr, i0);
            chk("bp_pc", pc, p0);
            chk("bp_noreq", {31'd0, imem_req_valid}, 32'd0);
        end
        npc_op = op;
        ra = r;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        npc_op = 4'd0;
        ra = 32'd0;
    endtask

    initial begin
        npc_op = 4'd0;
        ra = 32'd0;
        imem_rsp_data = 32'd0;
        do_reset();

        // sequential fetch, one instruction per 3 cycles
        fetch(32'h3000, 32'h0000_0000, 0, 1);
        chk("pc4_3000", pc_plus4, 32'h3004);
        prev_hold = hold_cyc;
        commit(4'd0, 32'd0, 0);
        fetch(32'h3004, 32'h0000_0000, 0, 1);
        chk("thru_3", hold_cyc - prev_hold, 32'd3);
        prev_hold = hold_cyc;
        commit(4'd0, 32'd0, 0);
        fetch(32'h3008, 32'h0000_0000, 0, 1);
        chk("thru_3b", hold_cyc - prev_hold, 32'd3);
        commit(4'd0, 32'd0, 0);

        // branches: imm=-1 back to 0x3000, imm=3 to 0x3010
        do_reset();
        fetch(32'h3000, 32'h1000_FFFF, 0, 1);
        commit(4'd1, 32'd0, 0);
        fetch(32'h3000, 32'h1000_0003, 0, 1);
        commit(4'd1, 32'd0, 0);
        // jump target {pc4[31:28], 0xC10, 00} = 0x3040
        fetch(32'h3010, 32'h0800_0C10, 0, 1);
        chk("jal_link", pc_plus4, 32'h3014);
        commit(4'd2, 32'd0, 0);
        // aligned JR
        fetch(32'h3040, 32'h03E0_0008, 0, 1);
        commit(4'd3, 32'h3100, 0);

        // stalls everywhere; decode ready high outside HOLD is ignored,
        // opcode 7 behaves as PLUS4
        instr_ready = 1'b1;
        npc_op = 4'd2;
        fetch(32'h3100, 32'h0800_0000, 4, 4);
        commit(4'd7, 32'h0000_0005, 5);

        // misaligned JR halts fetch
        fetch(32'h3104, 32'h03E0_0008, 0, 1);
        commit(4'd3, 32'h3102, 0);
        for (int i = 0; i < 5; i++) begin
            imem_req_ready = 1'b1;
            chk("halt_exc", {31'd0, exc_misalign}, 32'd1);
            chk("halt_noreq", {31'd0, imem_req_valid}, 32'd0);
            chk("halt_ivalid", {31'd0, instr_valid}, 32'd0);
            tick();
        end
        chk("halt_pc", pc, 32'h3104);
        chk("req_count", req_cnt, exp_req);

        // reset while waiting; stale response dropped
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        exp_req++;
        chk("abandon_wait", {31'd0, imem_req_valid}, 32'd0);
        rstn = 1'b0;
        tick();
        chk("mid_rst_req", {31'd0, imem_req_valid}, 32'd0);
        rstn = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        chk("stale_ivalid", {31'd0, instr_valid}, 32'd0);
        chk("stale_instr", instr, 32'd0);
        chk("refetch_addr", imem_addr, 32'h3000);
        fetch(32'h3000, 32'h1234_5678, 0, 2);

        // wrap of PC+4 at top of address space
        commit(4'd3, 32'hFFFF_FFFC, 0);
        fetch(32'hFFFF_FFFC, 32'h0000_0000, 0, 1);
        chk("wrap_pc4", pc_plus4, 32'd0);
        commit(4'd0, 32'd0, 0);
        fetch(32'h0000_0000, 32'h0000_0000, 0, 1);
        chk("req_count2", req_cnt, exp_req);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
